// File: rtl/be8_bus_resp.sv
// be8 bus memory responder: decodes an address window, serves a small byte array,
// and inserts a fixed number of wait states before raising ready.
module be8_bus_resp #(
    parameter int          AW   = 4,
    parameter logic [7:0]  BASE = 8'h00,
    parameter int          WAIT = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] addr,
    input  logic       rw,
    inout  wire  [7:0] data,
    output logic       ready,
    output logic       err
);

    localparam logic [3:0] WAIT_CNT = 4'(WAIT);

    typedef enum logic {WAITING, DONE} state_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic [7:0]  rdata, rdata_nxt;
    logic        rdy_q, rdy_nxt;
    logic        err_q, err_nxt;
    logic [16:0] key, key_q, key_q_nxt;
    logic        key_v, key_v_nxt;
    logic        new_acc, hit, complete, drive;
    logic [AW-1:0] idx;

    logic [7:0] mem [2**AW];

    assign key      = {addr, rw, rw ? data : 8'h00};
    assign new_acc  = !key_v || (key != key_q);
    assign hit      = (addr[7:AW] == BASE[7:AW]);
    assign idx      = addr[AW-1:0];
    assign complete = !new_acc && (state == WAITING) && (cnt == 4'd0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= WAITING;
            cnt   <= WAIT_CNT;
            rdata <= 8'h00;
            rdy_q <= 1'b0;
            err_q <= 1'b0;
            key_q <= '0;
            key_v <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            rdata <= rdata_nxt;
            rdy_q <= rdy_nxt;
            err_q <= err_nxt;
            key_q <= key_q_nxt;
            key_v <= key_v_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        rdata_nxt = rdata;
        rdy_nxt   = rdy_q;
        err_nxt   = err_q;
        key_q_nxt = key_q;
        key_v_nxt = key_v;
        if (new_acc) begin
            key_q_nxt = key;
            key_v_nxt = 1'b1;
            state_nxt = WAITING;
            cnt_nxt   = WAIT_CNT;
            rdy_nxt   = 1'b0;
            err_nxt   = 1'b0;
        end else if (state == WAITING) begin
            if (cnt != 4'd0) begin
                cnt_nxt = cnt - 4'd1;
            end else begin
                state_nxt = DONE;
                rdy_nxt   = 1'b1;
                err_nxt   = !hit;
                if (!rw)
                    rdata_nxt = hit ? mem[idx] : 8'hff;
            end
        end
    end

    // Array is deliberately not reset; a write commits only on the completing edge.
    always_ff @(posedge clk) begin
        if (complete && rw && hit)
            mem[idx] <= data;
    end

    // The drive enable avoids reading data back: for a read the key's data field is
    // always zero, so matching addr and rw against key_q is the same as key == key_q.
    always_comb begin
        ready = rdy_q && key_v && (key == key_q);
        err   = err_q && ready;
        drive = (state == DONE) && rdy_q && key_v && !rw && !key_q[8]
                && (addr == key_q[16:9]);
    end

    assign data = drive ? rdata : 8'hzz;

endmodule

// File: tb/tb_be8_bus_resp.sv
// Directed bench for be8_bus_resp: vector table of single accesses plus
// hand-written reset, abort, hold and zero-wait sequences.
module tb_be8_bus_resp;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] addr = 8'h00;
    logic       rw = 1'b0;
    logic [7:0] wd = 8'h00;
    wire  [7:0] data;
    logic       ready, err;

    logic       rw0 = 1'b0;
    logic [7:0] addr0 = 8'h00;
    logic [7:0] wd0 = 8'h00;
    wire  [7:0] data0;
    logic       ready0, err0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    assign data  = rw  ? wd  : 8'hzz;
    assign data0 = rw0 ? wd0 : 8'hzz;

    be8_bus_resp #(.AW(4), .BASE(8'h00), .WAIT(2)) u_dut (
        .clk(clk), .rst(rst), .addr(addr), .rw(rw), .data(data), .ready(ready), .err(err)
    );

    be8_bus_resp #(.AW(4), .BASE(8'h00), .WAIT(0)) u_dut0 (
        .clk(clk), .rst(rst), .addr(addr0), .rw(rw0), .data(data0), .ready(ready0), .err(err0)
    );

    typedef struct {
        logic [7:0] a;
        logic       w;
        logic [7:0] d;
        logic       exp_err;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Counts rising edges until ready is seen, sampling 1 ns after each edge.
    task automatic wait_ready(output int n);
        n = 0;
        while (n < 20) begin
            @(posedge clk);
            #1;
            n++;
            if (ready) break;
        end
        if (!ready) n = 99;
    endtask

    task automatic do_access(input string name, input logic [7:0] a, input logic w,
                             input logic [7:0] d, input logic exp_err, input logic [7:0] exp_data);
        int n;
        @(negedge clk);
        addr = a;
        rw   = w;
        wd   = d;
        #1;
        check({name, "_drop"}, 32'(ready), 32'd0);
        @(posedge clk);
        wait_ready(n);
        check({name, "_lat"}, 32'(n), 32'd3);
        check({name, "_err"}, 32'(err), 32'(exp_err));
        if (!w)
            check({name, "_data"}, 32'(data), 32'(exp_data));
    endtask

    initial begin
        int n;
        logic [3:0] ii;

        vecs[0]  = '{8'h07, 1'b1, 8'h5a, 1'b0, 8'h00};
        vecs[1]  = '{8'h07, 1'b0, 8'h00, 1'b0, 8'h5a};
        vecs[2]  = '{8'h20, 1'b0, 8'h00, 1'b1, 8'hff};
        vecs[3]  = '{8'h20, 1'b1, 8'h11, 1'b1, 8'h00};
        vecs[4]  = '{8'h0f, 1'b1, 8'ha5, 1'b0, 8'h00};
        vecs[5]  = '{8'h0f, 1'b0, 8'h00, 1'b0, 8'ha5};
        vecs[6]  = '{8'h07, 1'b0, 8'h00, 1'b0, 8'h5a};
        vecs[7]  = '{8'h00, 1'b1, 8'h3c, 1'b0, 8'h00};
        vecs[8]  = '{8'h00, 1'b1, 8'hc3, 1'b0, 8'h00};
        vecs[9]  = '{8'h00, 1'b0, 8'h00, 1'b0, 8'hc3};
        vecs[10] = '{8'hff, 1'b0, 8'h00, 1'b1, 8'hff};
        vecs[11] = '{8'h10, 1'b0, 8'h00, 1'b1, 8'hff};

        // Reset held for 3 cycles with random bus activity
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            addr = 8'($urandom);
            rw   = 1'($urandom);
            wd   = 8'($urandom);
            @(posedge clk);
            #1;
            check("rst_ready", 32'(ready), 32'd0);
            check("rst_err", 32'(err), 32'd0);
        end
        @(negedge clk);
        addr = 8'h03;
        rw   = 1'b0;
        rst  = 1'b1;
        wait_ready(n);
        check("rst_release_lat", 32'(n), 32'd4);
        check("rst_release_err", 32'(err), 32'd0);

        for (int i = 0; i < 12; i++)
            do_access($sformatf("vec%0d", i), vecs[i].a, vecs[i].w, vecs[i].d,
                      vecs[i].exp_err, vecs[i].exp_data);

        // Fill every entry, then confirm out-of-window writes leave it untouched
        for (int i = 0; i < 16; i++) begin
            ii = 4'(i);
            do_access($sformatf("fill%0d", i), {4'h0, ii}, 1'b1, {ii, ~ii}, 1'b0, 8'h00);
        end
        do_access("oow_wr20", 8'h20, 1'b1, 8'h11, 1'b1, 8'h00);
        do_access("oow_wrf2", 8'hf2, 1'b1, 8'h11, 1'b1, 8'h00);
        for (int i = 0; i < 16; i++) begin
            ii = 4'(i);
            do_access($sformatf("dump%0d", i), {4'h0, ii}, 1'b0, 8'h00, 1'b0, {ii, ~ii});
        end

        // Abort a write at cnt = 1 by switching to a read of another entry
        @(negedge clk);
        addr = 8'h02; rw = 1'b1; wd = 8'hc3;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        addr = 8'h04; rw = 1'b0;
        #1;
        check("abort_drop", 32'(ready), 32'd0);
        @(posedge clk);
        wait_ready(n);
        check("abort_rd4_lat", 32'(n), 32'd3);
        check("abort_rd4_data", 32'(data), 32'h4b);
        // Held key after completion: ready and data stay, no new access
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("hold_ready", 32'(ready), 32'd1);
            check("hold_data", 32'(data), 32'h4b);
        end
        do_access("abort_rd2", 8'h02, 1'b0, 8'h00, 1'b0, 8'h2d);

        // Reset during a write wait; same write restarts from scratch afterwards
        @(negedge clk);
        addr = 8'h09; rw = 1'b1; wd = 8'h5e;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_ready", 32'(ready), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        wait_ready(n);
        check("midrst_lat", 32'(n), 32'd4);
        check("midrst_err", 32'(err), 32'd0);
        do_access("midrst_rd9", 8'h09, 1'b0, 8'h00, 1'b0, 8'h5e);

        // Zero-wait instance: ready one edge after the key is sampled
        @(negedge clk);
        addr0 = 8'h05; rw0 = 1'b1; wd0 = 8'h9c;
        @(posedge clk);
        #1;
        check("w0_wr_edge0", 32'(ready0), 32'd0);
        @(posedge clk);
        #1;
        check("w0_wr_ready", 32'(ready0), 32'd1);
        @(negedge clk);
        rw0 = 1'b0;
        #1;
        check("w0_rd_drop", 32'(ready0), 32'd0);
        @(posedge clk);
        #1;
        check("w0_rd_edge0", 32'(ready0), 32'd0);
        @(posedge clk);
        #1;
        check("w0_rd_ready", 32'(ready0), 32'd1);
        check("w0_rd_data", 32'(data0), 32'h9c);
        check("w0_rd_err", 32'(err0), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
